// File: rtl/spi_cfg_master.sv
// SPI configuration master: parametrised frame, runtime CPOL/CPHA, multiple chip selects,
// programmable CS setup/hold and abort on enable loss. All outputs are registered.
module spi_cfg_master #(
   parameter int ADDR_W   = 8,
   parameter int DATA_W   = 16,
   parameter int NUM_CS   = 1,
   parameter int CLK_DIV  = 2,
   parameter int CS_SETUP = 1,
   parameter int CS_HOLD  = 1,
   localparam int FRAME_W = ADDR_W + DATA_W,
   localparam int CS_W    = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
   input  logic               spi_clk,
   input  logic               rst,
   input  logic               SPI_EN,
   input  logic               start,
   input  logic               rd,
   input  logic               cpol,
   input  logic               cpha,
   input  logic [CS_W-1:0]    cs_sel,
   input  logic [ADDR_W-1:0]  addr,
   input  logic [DATA_W-1:0]  wr_data,
   input  logic               SPI_MISO,
   output logic [NUM_CS-1:0]  SPI_CS_Z,
   output logic               SPI_MOSI,
   output logic               SPI_SCLK,
   output logic               SPI_BUSY,
   output logic               SPI_READ_DONE,
   output logic [FRAME_W-1:0] read_data
);

   // state   | meaning
   // IDLE    | waiting for start with SPI_EN high; SCLK parked at latched cpol
   // SETUP   | CS asserted, SCLK idle, CS_SETUP cycles
   // SHIFT   | 2*FRAME_W SCLK edges, CLK_DIV cycles apart
   // HOLD    | SCLK idle, CS still asserted, CS_HOLD cycles
   // DONE    | CS released, read result published
   typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_DONE} state_t;

   localparam int CNT_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int DIV_W   = $clog2(CLK_DIV + 1);
   localparam int EDGE_W  = $clog2(2 * FRAME_W + 1);

   state_t               state_q, state_n;
   logic [CNT_W-1:0]     cnt_q, cnt_n;
   logic [DIV_W-1:0]     div_q, div_n;
   logic [EDGE_W-1:0]    edge_q, edge_n;
   logic [FRAME_W-1:0]   shreg_q, shreg_n;
   logic [FRAME_W-1:0]   rx_q, rx_n;
   logic [FRAME_W-1:0]   rdata_q, rdata_n;
   logic [NUM_CS-1:0]    cs_z_q, cs_z_n, cs_dec;
   logic                 rd_q, rd_n, cpol_q, cpol_n, cpha_q, cpha_n;
   logic                 sclk_q, sclk_n, mosi_q, mosi_n;
   logic                 busy_q, busy_n, done_q, done_n;
   logic                 toggle, leading, last_edge;

   always_comb begin
      cs_dec = '1;
      for (int i = 0; i < NUM_CS; i++) begin
         if (cs_sel == CS_W'(i)) cs_dec[i] = 1'b0;
      end
   end

   always_comb begin
      state_n   = state_q;
      cnt_n     = cnt_q;
      div_n     = div_q;
      edge_n    = edge_q;
      shreg_n   = shreg_q;
      rx_n      = rx_q;
      rdata_n   = rdata_q;
      cs_z_n    = cs_z_q;
      rd_n      = rd_q;
      cpol_n    = cpol_q;
      cpha_n    = cpha_q;
      sclk_n    = sclk_q;
      mosi_n    = mosi_q;
      done_n    = 1'b0;
      toggle    = 1'b0;
      leading   = (sclk_q == cpol_q);
      last_edge = (state_q == S_SHIFT) && (edge_q == EDGE_W'(1));

      if (!SPI_EN) begin
         if (state_q != S_IDLE) begin
            state_n = S_IDLE;
            cs_z_n  = '1;
            sclk_n  = cpol_q;
            mosi_n  = 1'b1;
         end
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_n = S_SETUP;
                  cnt_n   = CNT_W'(CS_SETUP - 1);
                  shreg_n = {addr, wr_data};
                  rd_n    = rd;
                  cpol_n  = cpol;
                  cpha_n  = cpha;
                  cs_z_n  = cs_dec;
                  sclk_n  = cpol;
                  mosi_n  = cpha ? 1'b1 : addr[ADDR_W-1];
               end
            end
            S_SETUP: begin
               if (cnt_q != '0) begin
                  cnt_n = cnt_q - 1'b1;
               end else begin
                  state_n = S_SHIFT;
                  div_n   = DIV_W'(CLK_DIV - 1);
                  edge_n  = EDGE_W'(2 * FRAME_W - 1);
                  toggle  = 1'b1;
               end
            end
            S_SHIFT: begin
               if (div_q != '0) begin
                  div_n = div_q - 1'b1;
               end else if (edge_q != '0) begin
                  toggle = 1'b1;
                  edge_n = edge_q - 1'b1;
                  div_n  = DIV_W'(CLK_DIV - 1);
               end else begin
                  state_n = S_HOLD;
                  cnt_n   = CNT_W'(CS_HOLD - 1);
               end
            end
            S_HOLD: begin
               if (cnt_q != '0) begin
                  cnt_n = cnt_q - 1'b1;
               end else begin
                  state_n = S_DONE;
                  cs_z_n  = '1;
                  mosi_n  = 1'b1;
                  if (rd_q) begin
                     done_n  = 1'b1;
                     rdata_n = rx_q;
                  end
               end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
         endcase
      end

      // MISO is captured in the same spi_clk cycle that registers the sampling edge
      if (toggle) begin
         sclk_n = ~sclk_q;
         if (leading ^ cpha_q) rx_n = {rx_q[FRAME_W-2:0], SPI_MISO};
         if (cpha_q && leading) begin
            mosi_n  = shreg_q[FRAME_W-1];
            shreg_n = shreg_q << 1;
         end else if (!cpha_q && !leading && !last_edge) begin
            mosi_n  = shreg_q[FRAME_W-2];
            shreg_n = shreg_q << 1;
         end
      end

      busy_n = (state_n != S_IDLE);
   end

   always_ff @(posedge spi_clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         div_q   <= '0;
         edge_q  <= '0;
         shreg_q <= '0;
         rx_q    <= '0;
         rdata_q <= '0;
         cs_z_q  <= '1;
         rd_q    <= 1'b0;
         cpol_q  <= 1'b0;
         cpha_q  <= 1'b0;
         sclk_q  <= 1'b0;
         mosi_q  <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_n;
         cnt_q   <= cnt_n;
         div_q   <= div_n;
         edge_q  <= edge_n;
         shreg_q <= shreg_n;
         rx_q    <= rx_n;
         rdata_q <= rdata_n;
         cs_z_q  <= cs_z_n;
         rd_q    <= rd_n;
         cpol_q  <= cpol_n;
         cpha_q  <= cpha_n;
         sclk_q  <= sclk_n;
         mosi_q  <= mosi_n;
         busy_q  <= busy_n;
         done_q  <= done_n;
      end
   end

   assign SPI_CS_Z      = cs_z_q;
   assign SPI_MOSI      = mosi_q;
   assign SPI_SCLK      = sclk_q;
   assign SPI_BUSY      = busy_q;
   assign SPI_READ_DONE = done_q;
   assign read_data     = rdata_q;

endmodule
